// File: rtl/fir_frame_sequencer.sv
// fir_frame_sequencer: streams a frame into a FIR filter, flushes the delay line and drains its outputs; FIR_SEQ_ABORT_EN adds an abort input
module fir_frame_sequencer #(
  parameter int DATA_WIDTH    = 16,
  parameter int NUM_TAPS      = 53,
  parameter int OUTPUT_WIDTH  = 38,
  parameter int MAX_FRAME     = 4096,
  parameter int DRAIN_TIMEOUT = 256,
  parameter int LEN_WIDTH     = $clog2(MAX_FRAME + 1),
  parameter int CNT_WIDTH     = $clog2(MAX_FRAME + NUM_TAPS)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [LEN_WIDTH-1:0]    frame_len,
  input  logic                    s_valid,
  input  logic [DATA_WIDTH-1:0]   s_data,
  output logic                    s_ready,
  output logic                    fir_valid,
  output logic [DATA_WIDTH-1:0]   fir_data,
  input  logic                    fir_o_valid,
  input  logic [OUTPUT_WIDTH-1:0] fir_o_data,
  output logic                    m_valid,
  output logic [OUTPUT_WIDTH-1:0] m_data,
  output logic                    m_last,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
`ifdef FIR_SEQ_ABORT_EN
  input  logic                    abort,
`endif
  output logic [CNT_WIDTH-1:0]    out_count
);
  localparam int FW = $clog2(NUM_TAPS);
  localparam int IW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_STREAM = 3'd1;
  localparam logic [2:0] S_FLUSH  = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  logic [2:0]              r_state;
  logic [LEN_WIDTH-1:0]    r_len;
  logic [LEN_WIDTH-1:0]    r_in_cnt;
  logic [CNT_WIDTH-1:0]    r_total;
  logic [CNT_WIDTH-1:0]    r_out_cnt;
  logic [FW-1:0]           r_flush;
  logic [IW-1:0]           r_idle;
  logic                    r_done;
  logic                    r_err;
  logic                    r_fir_valid;
  logic [DATA_WIDTH-1:0]   r_fir_data;
  logic                    r_m_valid;
  logic                    r_m_last;
  logic [OUTPUT_WIDTH-1:0] r_m_data;
  logic                    w_hs;
  logic                    w_abort;
  logic                    w_start_ok;
  logic                    w_accept;
  logic                    w_take;
  logic                    w_timeout;
  logic [LEN_WIDTH-1:0]    w_in_nxt;
`ifdef FIR_SEQ_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif
  assign s_ready    = r_state == S_STREAM;
  assign busy       = r_state != S_IDLE;
  assign w_hs       = s_ready & s_valid;
  assign w_in_nxt   = r_in_cnt + LEN_WIDTH'(w_hs);
  assign w_start_ok = frame_len != '0 && frame_len <= LEN_WIDTH'(MAX_FRAME);
  assign w_accept   = r_state == S_IDLE && start && w_start_ok;
  assign w_take     = fir_o_valid && (r_state == S_STREAM || r_state == S_FLUSH || r_state == S_DRAIN) && r_out_cnt < r_total;
  assign w_timeout  = r_state == S_DRAIN && !fir_o_valid && r_idle == IW'(DRAIN_TIMEOUT - 1);
  assign done       = r_state == S_DONE || r_done;
  assign err        = r_err;
  assign fir_valid  = r_fir_valid;
  assign fir_data   = r_fir_data;
  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign m_last     = r_m_last;
  assign out_count  = r_out_cnt;
  // frame control: start/length check, stream count, flush length, drain watchdog
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_len    <= '0;
      r_in_cnt <= '0;
      r_total  <= '0;
      r_flush  <= '0;
      r_idle   <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_len    <= frame_len;
            r_total  <= CNT_WIDTH'(frame_len) + CNT_WIDTH'(NUM_TAPS - 1);
            r_in_cnt <= '0;
            r_state  <= S_STREAM;
          end else if (start) begin
            r_err <= 1'b1;
          end
        end
        S_STREAM: begin
          r_in_cnt <= w_in_nxt;
          r_flush  <= '0;
          if (w_abort && w_in_nxt == '0) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else if (w_abort) begin
            r_total <= CNT_WIDTH'(w_in_nxt) + CNT_WIDTH'(NUM_TAPS - 1);
            r_state <= S_FLUSH;
          end else if (w_hs && r_in_cnt == r_len - 1'b1) begin
            r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          r_flush <= r_flush + 1'b1;
          r_idle  <= '0;
          if (r_flush == FW'(NUM_TAPS - 2)) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          r_idle <= fir_o_valid ? '0 : r_idle + 1'b1;
          if (r_out_cnt == r_total) begin
            r_state <= S_DONE;
          end else if (w_timeout) begin
            r_state <= S_IDLE;
            r_err   <= 1'b1;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  // filter input stage: one-cycle registered samples, zeros while flushing
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fir_valid <= 1'b0;
      r_fir_data  <= '0;
    end else begin
      r_fir_valid <= w_hs || r_state == S_FLUSH;
      r_fir_data  <= w_hs ? s_data : '0;
    end
  end
  // output forwarding: count accepted filter outputs and flag the last one
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_data  <= '0;
      r_out_cnt <= '0;
    end else begin
      r_m_valid <= w_take;
      r_m_last  <= w_take && r_out_cnt + CNT_WIDTH'(1) == r_total;
      if (w_take) r_m_data <= fir_o_data;
      if (w_accept) r_out_cnt <= '0;
      else if (w_take) r_out_cnt <= r_out_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_fir_frame_sequencer.sv
// tb_fir_frame_sequencer: directed frame tests against a 3-cycle behavioural filter (gain 3)
module tb_fir_frame_sequencer;
  localparam int DW = 16;
  localparam int OW = 38;
  localparam int LW = 13;
  localparam int CW = 13;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic [LW-1:0] frame_len = '0;
  logic s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic s_ready, fir_valid, fir_o_valid, m_valid, m_last, busy, done, err;
  logic [DW-1:0] fir_data;
  logic [OW-1:0] fir_o_data, m_data;
  logic [CW-1:0] out_count;
`ifdef FIR_SEQ_ABORT_EN
  logic abort = 1'b0;
`endif
  logic spur = 1'b0;
  logic mon_clr = 1'b0;
  int mon_len = 0;
  int f_limit = 1000000;
  int f_cnt = 0;
  logic [2:0] f_v = '0;
  logic [DW-1:0] f_d0 = '0, f_d1 = '0, f_d2 = '0;
  int checks = 0;
  int failures = 0;
  int fv_n = 0, mv_n = 0, last_n = 0, last_at = 0, done_n = 0, err_n = 0, both_n = 0, bad = 0, bad_fv = 0, bub_n = 0;

  fir_frame_sequencer dut (
    .clk(clk), .resetn(resetn), .start(start), .frame_len(frame_len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .fir_valid(fir_valid), .fir_data(fir_data),
    .fir_o_valid(fir_o_valid), .fir_o_data(fir_o_data),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done), .err(err),
`ifdef FIR_SEQ_ABORT_EN
    .abort(abort),
`endif
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] smp(input int k);
    return DW'(k * 371 - 3000);
  endfunction

  function automatic logic [OW-1:0] filt(input logic [DW-1:0] x);
    logic [OW-1:0] t;
    t = {{(OW-DW){x[DW-1]}}, x};
    return t + t + t;
  endfunction

  always @(posedge clk) begin
    f_v  <= {f_v[1:0], fir_valid};
    f_d0 <= fir_data;
    f_d1 <= f_d0;
    f_d2 <= f_d1;
    if (mon_clr) f_cnt <= 0;
    else if (fir_o_valid && !spur) f_cnt <= f_cnt + 1;
  end
  assign fir_o_valid = (f_v[2] && f_cnt < f_limit) || spur;
  assign fir_o_data  = filt(f_d2);

  always @(negedge clk) begin
    if (mon_clr) begin
      fv_n <= 0; mv_n <= 0; last_n <= 0; last_at <= 0; done_n <= 0;
      err_n <= 0; both_n <= 0; bad <= 0; bad_fv <= 0; bub_n <= 0;
    end else begin
      if (fir_valid) begin
        if (fir_data !== (fv_n < mon_len ? smp(fv_n) : '0)) bad <= bad + 1;
        fv_n <= fv_n + 1;
      end
      if (fir_valid && !busy) bad_fv <= bad_fv + 1;
      if (s_ready && fv_n > 0 && !fir_valid) bub_n <= bub_n + 1;
      if (m_valid) begin
        if (m_data !== (mv_n < mon_len ? filt(smp(mv_n)) : '0)) bad <= bad + 1;
        mv_n <= mv_n + 1;
        if (m_last) begin
          last_n  <= last_n + 1;
          last_at <= mv_n + 1;
        end
      end
      if (done) done_n <= done_n + 1;
      if (err) err_n <= err_n + 1;
      if (done && err) both_n <= both_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr(input int len);
    mon_len = len;
    @(negedge clk);
    #2 mon_clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 mon_clr = 1'b0;
  endtask

  task automatic do_start(input int len);
    @(negedge clk);
    start = 1'b1;
    frame_len = LW'(len);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic stream(input int n, input bit toggle);
    int k = 0;
    int cyc = 0;
    while (k < n && cyc < 5000) begin
      s_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      s_data = smp(k);
      #1;
      if (s_valid && s_ready) k++;
      cyc++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    chk("stream_count", 64'(k), 64'(n));
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int i = 0;
    while (busy && i < limit) begin
      @(negedge clk);
      i++;
    end
    chk(tag, busy, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_flags", {busy, s_ready, fir_valid, m_valid, m_last, done, err}, 0);
    chk("rst_count", out_count, 0);
    chk("rst_data", {fir_data, m_data}, 0);
    resetn = 1'b1;
    // frame of 512 with continuous input
    clr(512);
    do_start(512);
    stream(512, 1'b0);
    wait_idle("t1_idle", 2000);
    chk("t1_fir_valid", fv_n, 564);
    chk("t1_m_valid", mv_n, 564);
    chk("t1_last_n", last_n, 1);
    chk("t1_last_at", last_at, 564);
    chk("t1_done", done_n, 1);
    chk("t1_err", err_n, 0);
    chk("t1_out_count", out_count, 564);
    chk("t1_data", bad, 0);
    chk("t1_fv_idle", bad_fv, 0);
    // short frame with toggled valid
    clr(8);
    do_start(8);
    stream(8, 1'b1);
    wait_idle("t2_idle", 1000);
    chk("t2_bubble", bub_n > 0, 1);
    chk("t2_m_valid", mv_n, 60);
    chk("t2_fir_valid", fv_n, 60);
    chk("t2_last_at", last_at, 60);
    chk("t2_done", done_n, 1);
    chk("t2_data", bad, 0);
    // illegal frame lengths
    clr(0);
    do_start(0);
    chk("t3_err_len0", err, 1);
    chk("t3_busy_len0", busy, 0);
    do_start(4097);
    chk("t3_err_len4097", err, 1);
    chk("t3_busy_len4097", busy, 0);
    repeat (2) @(negedge clk);
    chk("t3_err_n", err_n, 2);
    chk("t3_fir_valid", fv_n, 0);
    spur = 1'b1;
    repeat (3) @(negedge clk);
    spur = 1'b0;
    repeat (2) @(negedge clk);
    chk("t3_idle_drop", mv_n, 0);
    // start while busy is ignored
    clr(8);
    do_start(8);
    start = 1'b1;
    frame_len = LW'(5);
    @(negedge clk);
    start = 1'b0;
    stream(8, 1'b0);
    wait_idle("t4_idle", 1000);
    chk("t4_m_valid", mv_n, 60);
    chk("t4_out_count", out_count, 60);
    chk("t4_last_at", last_at, 60);
    chk("t4_err", err_n, 0);
    // reset during flush
    clr(8);
    do_start(8);
    stream(8, 1'b0);
    repeat (5) @(negedge clk);
    chk("t4_pre_rst_busy", busy, 1);
    resetn = 1'b0;
    #1;
    chk("t4_rst_flags", {busy, s_ready, fir_valid, m_valid, m_last, done, err}, 0);
    chk("t4_rst_count", out_count, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("t4_post_rst_busy", busy, 0);
    clr(8);
    do_start(8);
    stream(8, 1'b1);
    wait_idle("t4b_idle", 1000);
    chk("t4b_m_valid", mv_n, 60);
    chk("t4b_fir_valid", fv_n, 60);
    chk("t4b_done", done_n, 1);
    chk("t4b_data", bad, 0);
    // filter stalls after 20 outputs
    f_limit = 20;
    clr(8);
    do_start(8);
    stream(8, 1'b0);
    wait_idle("t5_idle", 1000);
    chk("t5_m_valid", mv_n, 20);
    chk("t5_out_count", out_count, 20);
    chk("t5_done_err", both_n, 1);
    chk("t5_done", done_n, 1);
    chk("t5_err", err_n, 1);
    chk("t5_last", last_n, 0);
    f_limit = 1000000;
`ifdef FIR_SEQ_ABORT_EN
    // abort after 10 samples
    clr(10);
    do_start(100);
    stream(10, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle("t6_idle", 1000);
    chk("t6_fir_valid", fv_n, 62);
    chk("t6_m_valid", mv_n, 62);
    chk("t6_last_at", last_at, 62);
    chk("t6_last_n", last_n, 1);
    chk("t6_done", done_n, 1);
    chk("t6_out_count", out_count, 62);
    chk("t6_data", bad, 0);
    // abort before any sample
    clr(0);
    do_start(100);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6b_busy", busy, 0);
    chk("t6b_done", done_n, 1);
    chk("t6b_out_count", out_count, 0);
    chk("t6b_err", err_n, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
